// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS fetch front end.
package mips_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned IDX_W  = 26;

  localparam logic [ADDR_W-1:0] RESET_VECTOR_DEF = 32'h0000_0000;
  localparam logic [ADDR_W-1:0] EXC_VECTOR_DEF   = 32'h0000_0180;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    WAIT = 2'd2
  } pc_state_e;

endpackage

// File: rtl/pc_sequencer_if.sv
// Control/redirect inputs and fetch-address outputs of the PC stage.
interface pc_sequencer_if;
  import mips_pkg::*;

  logic [ADDR_W-1:0] PCBranch;
  logic              PCSrc;
  logic              Jump;
  logic              JumpReg;
  logic [IDX_W-1:0]  InstrIndex;
  logic [ADDR_W-1:0] RegRs;
  logic              ImemReady;
  logic              Stall;
  logic              FaultClear;
  logic [ADDR_W-1:0] PC;
  logic [ADDR_W-1:0] PCPlus4;
  logic              PCValid;
  logic              MisalignFault;
  logic [ADDR_W-1:0] FaultAddr;
  logic [ADDR_W-1:0] FetchCount;

  modport master (
    output PCBranch, PCSrc, Jump, JumpReg, InstrIndex, RegRs,
    output ImemReady, Stall, FaultClear,
    input  PC, PCPlus4, PCValid, MisalignFault, FaultAddr, FetchCount
  );

  modport slave (
    input  PCBranch, PCSrc, Jump, JumpReg, InstrIndex, RegRs,
    input  ImemReady, Stall, FaultClear,
    output PC, PCPlus4, PCValid, MisalignFault, FaultAddr, FetchCount
  );

endinterface

// File: rtl/next_pc_mux.sv
// Priority next-PC select (jr > j > branch > sequential) with jr alignment check.
module next_pc_mux
  import mips_pkg::*;
#(
  parameter logic [ADDR_W-1:0] EXC_VECTOR = EXC_VECTOR_DEF
) (
  input  logic [ADDR_W-1:0] pc_plus4,
  input  logic [ADDR_W-1:0] pc_branch,
  input  logic              pc_src,
  input  logic              jump,
  input  logic              jump_reg,
  input  logic [IDX_W-1:0]  instr_index,
  input  logic [ADDR_W-1:0] reg_rs,
  output logic [ADDR_W-1:0] target_c,
  output logic              fault_c
);

  always_comb begin
    target_c = pc_plus4;
    fault_c  = 1'b0;
    if (jump_reg) begin
      if (reg_rs[1:0] != 2'b00) begin
        target_c = EXC_VECTOR;
        fault_c  = 1'b1;
      end else begin
        target_c = reg_rs;
      end
    end else if (jump) begin
      target_c = {pc_plus4[31:28], instr_index, 2'b00};
    end else if (pc_src) begin
      target_c = pc_branch;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter stage: boot/run/wait FSM, PC register, sticky jr fault, fetch counter.
module pc_sequencer
  import mips_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_VECTOR = RESET_VECTOR_DEF,
  parameter logic [ADDR_W-1:0] EXC_VECTOR   = EXC_VECTOR_DEF
) (
  input  logic            clk,
  input  logic            rst,
  pc_sequencer_if.slave   bus
);

  pc_state_e         state_q;
  pc_state_e         state_d;
  logic              advance_c;
  logic [ADDR_W-1:0] pc_q;
  logic              pc_valid_q;
  logic              fault_q;
  logic [ADDR_W-1:0] fault_addr_q;
  logic [ADDR_W-1:0] fetch_cnt_q;
  logic [ADDR_W-1:0] target_c;
  logic              fault_det_c;
  logic [ADDR_W-1:0] pc_plus4_c;

  assign pc_plus4_c = pc_q + ADDR_W'(4);

  next_pc_mux #(.EXC_VECTOR(EXC_VECTOR)) u_mux (
    .pc_plus4    (pc_plus4_c),
    .pc_branch   (bus.PCBranch),
    .pc_src      (bus.PCSrc),
    .jump        (bus.Jump),
    .jump_reg    (bus.JumpReg),
    .instr_index (bus.InstrIndex),
    .reg_rs      (bus.RegRs),
    .target_c    (target_c),
    .fault_c     (fault_det_c)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= BOOT;
    else      state_q <= state_d;
  end

  // Only a RUN cycle with ready memory and no stall moves the PC.
  always_comb begin
    state_d   = state_q;
    advance_c = 1'b0;
    case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        if (!bus.ImemReady)  state_d = WAIT;
        else if (!bus.Stall) advance_c = 1'b1;
      end
      WAIT: if (bus.ImemReady) state_d = RUN;
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q         <= RESET_VECTOR;
      pc_valid_q   <= 1'b0;
      fault_q      <= 1'b0;
      fault_addr_q <= '0;
      fetch_cnt_q  <= '0;
    end else begin
      pc_valid_q <= (state_d != BOOT);
      if (advance_c) begin
        pc_q        <= target_c;
        fetch_cnt_q <= fetch_cnt_q + ADDR_W'(1);
      end
      // A new fault outranks a simultaneous clear.
      if (advance_c && fault_det_c) begin
        fault_q      <= 1'b1;
        fault_addr_q <= bus.RegRs;
      end else if (bus.FaultClear) begin
        fault_q <= 1'b0;
      end
    end
  end

  assign bus.PC            = pc_q;
  assign bus.PCPlus4       = pc_plus4_c;
  assign bus.PCValid       = pc_valid_q;
  assign bus.MisalignFault = fault_q;
  assign bus.FaultAddr     = fault_addr_q;
  assign bus.FetchCount    = fetch_cnt_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed plus randomized checks of pc_sequencer against a behavioural fetch model.
module tb_pc_sequencer;

  localparam logic [31:0] RV = 32'h0000_0000;
  localparam logic [31:0] EV = 32'h0000_0180;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  pc_sequencer_if bus();

  pc_sequencer #(.RESET_VECTOR(RV), .EXC_VECTOR(EV)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Model: a boot edge is pending, or a re-presentation after a memory stall is pending.
  logic [31:0] m_pc, m_faddr, m_cnt;
  logic        m_valid, m_fault;
  bit          m_boot_pending, m_refetch_pending;

  task automatic model_reset();
    m_pc = RV; m_faddr = 32'h0; m_cnt = 32'h0;
    m_valid = 1'b0; m_fault = 1'b0;
    m_boot_pending = 1'b1; m_refetch_pending = 1'b0;
  endtask

  task automatic model_edge();
    logic [31:0] p4, tgt;
    bit          newf;
    newf = 1'b0;
    if (m_boot_pending) begin
      m_boot_pending = 1'b0;
      m_valid = 1'b1;
    end else if (m_refetch_pending) begin
      if (bus.ImemReady) m_refetch_pending = 1'b0;
    end else if (!bus.ImemReady) begin
      m_refetch_pending = 1'b1;
    end else if (!bus.Stall) begin
      p4 = m_pc + 32'd4;
      if (bus.JumpReg) begin
        if (bus.RegRs % 4 != 0) begin
          tgt = EV; newf = 1'b1;
        end else tgt = bus.RegRs;
      end else if (bus.Jump) tgt = (p4 & 32'hF000_0000) | (32'(bus.InstrIndex) * 4);
      else if (bus.PCSrc) tgt = bus.PCBranch;
      else tgt = p4;
      m_pc  = tgt;
      m_cnt = m_cnt + 32'd1;
    end
    if (newf) begin
      m_fault = 1'b1; m_faddr = bus.RegRs;
    end else if (bus.FaultClear) m_fault = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("PC", bus.PC, m_pc);
    chk("PCPlus4", bus.PCPlus4, m_pc + 32'd4);
    chk("PCValid", 32'(bus.PCValid), 32'(m_valid));
    chk("MisalignFault", 32'(bus.MisalignFault), 32'(m_fault));
    chk("FaultAddr", bus.FaultAddr, m_faddr);
    chk("FetchCount", bus.FetchCount, m_cnt);
  endtask

  task automatic drive(input logic ready, input logic stall, input logic pcsrc,
                       input logic jump, input logic jr, input logic [31:0] br,
                       input logic [31:0] rs, input logic [25:0] idx, input logic fclr);
    bus.ImemReady = ready; bus.Stall = stall; bus.PCSrc = pcsrc;
    bus.Jump = jump; bus.JumpReg = jr; bus.PCBranch = br;
    bus.RegRs = rs; bus.InstrIndex = idx; bus.FaultClear = fclr;
  endtask

  task automatic idle();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 26'h0, 1'b0);
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    check_all();
  endtask

  logic [31:0] cnt_before, rs;

  initial begin
    idle();
    model_reset();
    // Reset and boot
    repeat (3) @(posedge clk);
    #1;
    check_all();
    rst = 1'b1;
    #1;
    chk("boot_valid_low", 32'(bus.PCValid), 32'h0);
    tick();
    chk("boot_pc", bus.PC, 32'h0);
    chk("boot_valid_high", 32'(bus.PCValid), 32'h1);
    tick();
    tick();
    chk("boot_pc8", bus.PC, 32'h8);
    chk("boot_cnt", bus.FetchCount, 32'h2);
    tick();
    tick();
    chk("at_0x10", bus.PC, 32'h10);

    // Branch, then branch+jump (jump wins)
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h40, 32'h0, 26'h0, 1'b0);
    tick();
    chk("branch", bus.PC, 32'h40);
    drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h80, 32'h0, 26'h100, 1'b0);
    tick();
    chk("jump_over_branch", bus.PC, 32'h400);

    // Jump keeps the PC+4 region bits
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h1000_0010, 32'h0, 26'h0, 1'b0);
    tick();
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 26'h100, 1'b0);
    tick();
    chk("jump_region", bus.PC, 32'h1000_0400);

    // Misaligned jr, then fault plus clear on the same edge
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h203, 26'h0, 1'b0);
    tick();
    chk("jr_exc_pc", bus.PC, 32'h180);
    chk("jr_fault", 32'(bus.MisalignFault), 32'h1);
    chk("jr_faddr", bus.FaultAddr, 32'h203);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h301, 26'h0, 1'b1);
    tick();
    chk("fault_wins", 32'(bus.MisalignFault), 32'h1);
    chk("faddr_update", bus.FaultAddr, 32'h301);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 26'h0, 1'b1);
    tick();
    chk("fault_cleared", 32'(bus.MisalignFault), 32'h0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0000_0800, 26'h0, 1'b0);
    tick();
    chk("jr_aligned", bus.PC, 32'h800);

    // Memory wait: 3 low cycles hold the PC for 4 edges
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h20, 32'h0, 26'h0, 1'b0);
    tick();
    cnt_before = bus.FetchCount;
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h500, 32'h0, 26'h3, 1'b0);
    repeat (3) begin
      tick();
      chk("wait_hold", bus.PC, 32'h20);
    end
    idle();
    tick();
    chk("wait_reissue", bus.PC, 32'h20);
    chk("wait_cnt", bus.FetchCount, cnt_before);
    tick();
    chk("wait_done", bus.PC, 32'h24);

    // Pipeline stall
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 26'h0, 1'b0);
    repeat (2) begin
      tick();
      chk("stall_hold", bus.PC, 32'h24);
    end
    idle();
    tick();
    chk("stall_done", bus.PC, 32'h28);

    // Address wrap
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0, 26'h0, 1'b0);
    tick();
    chk("wrap_pcplus4", bus.PCPlus4, 32'h0);
    idle();
    tick();
    chk("wrap_pc", bus.PC, 32'h0);

    // Random traffic
    repeat (400) begin
      rs = $urandom;
      if ($urandom_range(0, 1) == 0) rs = rs & 32'hFFFF_FFFC;
      drive(1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 5) == 0),
            1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 4) == 0),
            1'($urandom_range(0, 5) == 0), $urandom & 32'hFFFF_FFFC, rs,
            26'($urandom), 1'($urandom_range(0, 7) == 0));
      tick();
    end

    // Asynchronous reset while in WAIT
    idle();
    repeat (3) tick();
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h300, 32'h0, 26'h0, 1'b0);
    tick();
    chk("pre_reset_pc", bus.PC, 32'h300);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 26'h0, 1'b0);
    tick();
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    chk("async_rst_pc", bus.PC, RV);
    check_all();
    #2;
    rst = 1'b1;
    idle();
    tick();
    tick();
    chk("post_reset_pc", bus.PC, 32'h4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
